// File: rtl/gdo_seq_unit_if.sv
// gdo_seq_unit_if: operand/result channel bundle for the sequential data operator.
// Input side: in_valid/in_ready handshake carrying op, a, b.
// Output side: out_valid/out_ready handshake carrying out_data, out_sat.
interface gdo_seq_unit_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               op;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  // Upstream/downstream side (feeds operands, consumes results).
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/gdo_seq_unit.sv
// gdo_seq_unit: saturating signed fixed-point add/sub/mult/pow, one transaction at a time.
// Latency: add/sub/mult/pow(n=0) result visible the cycle after accept; pow(n>0) after n more edges.
// Backpressure: result held in DONE until out_ready; no new accept until the cycle after handshake.
// Ports: clk, rst (async, active-high); io = gdo_seq_unit_if.slave (op 0=add 1=sub 2=mult 3=pow,
//        pow exponent n = b[EXP_W-1:0] unsigned).
module gdo_seq_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int EXP_W  = 4
) (
  input logic           clk,
  input logic           rst,
  gdo_seq_unit_if.slave io
);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
  localparam logic signed [PW-1:0]     SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic                     clip;
    logic signed [DATA_W-1:0] val;
  } sat_t;

  function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{DATA_W{x[DATA_W-1]}}, x};
  endfunction

  // The full product always fits in PW bits, so the truncating multiply is exact;
  // the arithmetic shift gives floor rounding.
  function automatic logic signed [PW-1:0] fx_mul(input logic signed [DATA_W-1:0] x,
                                                  input logic signed [DATA_W-1:0] y);
    logic signed [PW-1:0] p;
    p = sext(x) * sext(y);
    return p >>> FRAC_W;
  endfunction

  function automatic sat_t saturate(input logic signed [PW-1:0] v);
    sat_t r;
    if (v > SAT_MAX) begin
      r.clip = 1'b1;
      r.val  = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      r.clip = 1'b1;
      r.val  = SAT_MIN[DATA_W-1:0];
    end else begin
      r.clip = 1'b0;
      r.val  = v[DATA_W-1:0];
    end
    return r;
  endfunction

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] acc, base, res_q;
  logic [EXP_W-1:0]         cnt;
  logic                     pow_sat, sat_q;
  logic                     ready, valid;
  logic signed [PW-1:0]     alu_wide;
  sat_t                     alu_res, step_res;
  logic [EXP_W-1:0]         exp_n;
  logic                     pow_iter, accept;

  assign exp_n    = io.b[EXP_W-1:0];
  assign pow_iter = (io.op == 2'd3) && (exp_n != '0);
  assign accept   = io.in_valid && ready;

  // Single-shot path; pow with n=0 falls through here and yields ONE.
  always_comb begin
    alu_wide = '0;
    case (io.op)
      2'd0:    alu_wide = sext(io.a) + sext(io.b);
      2'd1:    alu_wide = sext(io.a) - sext(io.b);
      2'd2:    alu_wide = fx_mul(io.a, io.b);
      default: alu_wide = sext(ONE);
    endcase
    alu_res = saturate(alu_wide);
  end

  assign step_res = saturate(fx_mul(acc, base));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = pow_iter ? CALC : DONE;
      CALC:    if (cnt == EXP_W'(1)) state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; in_ready also masked by rst so nothing is accepted during reset.
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE:    ready = !rst;
      DONE:    valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: out_data/out_sat only change on the edge entering DONE,
  // so partial pow accumulations are never exposed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      base    <= '0;
      cnt     <= '0;
      pow_sat <= 1'b0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (pow_iter) begin
              acc     <= ONE;
              base    <= io.a;
              cnt     <= exp_n;
              pow_sat <= 1'b0;
            end else begin
              res_q <= alu_res.val;
              sat_q <= alu_res.clip;
            end
          end
        end
        CALC: begin
          acc     <= step_res.val;
          pow_sat <= pow_sat | step_res.clip;
          cnt     <= cnt - EXP_W'(1);
          if (cnt == EXP_W'(1)) begin
            res_q <= step_res.val;
            sat_q <= pow_sat | step_res.clip;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = ready;
  assign io.out_valid = valid;
  assign io.out_data  = res_q;
  assign io.out_sat   = sat_q;
endmodule

// File: doc/gdo_seq_unit.md
Name: gdo_seq_unit

Overview:
- Parametrised, clocked successor to the general data operator.
- Executes one signed fixed-point operation per transaction: add, sub, mult or integer pow.
- Uses a valid/ready handshake on both input and output.
- Saturates results and reports saturation. Pow is computed iteratively by a multi-cycle FSM.
- Sits between neuron datapath stages that need shared arithmetic.

Parameters:
- DATA_W, 16, operand/result width; two's-complement signed.
- FRAC_W, 8, fractional bits; ONE = 1 << FRAC_W (must satisfy FRAC_W < DATA_W-1).
- EXP_W, 4, width of the pow exponent field taken from b[EXP_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept (high only in IDLE and rst low).
- op  in  2  0=add, 1=sub, 2=mult, 3=pow.
- a  in  DATA_W  signed operand A.
- b  in  DATA_W  signed operand B; for pow, unsigned exponent n = b[EXP_W-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  signed saturated result.
- out_sat  out  1  saturation occurred during this operation.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_sat=0; in_ready=0 while rst high.
- Saturation bounds: MAX = 2^(DATA_W-1)-1, MIN = -2^(DATA_W-1).
- Arithmetic:
  - add/sub: computed at DATA_W+1 bits, then saturated.
  - mult: full 2*DATA_W signed product, arithmetic shift right by FRAC_W (floor), then saturated.
  - pow: acc starts at ONE; each step acc = sat(floor((acc*a) >>> FRAC_W)).
  - out_sat is sticky across pow steps and set if any step clipped.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on clock edge where in_valid && in_ready.
  - add/sub/mult: result and sat registered on the accepting edge → DONE (latency 1: out_valid high the cycle after accept).
  - pow with n=0: out_data=ONE, sat=0 → DONE.
  - pow with n>0: acc=ONE, cnt=n, base=a latched → CALC.
- CALC:
  - One multiply-saturate per edge; cnt decrements.
  - Edge where cnt reaches 0 writes out_data/out_sat → DONE.
  - Pow latency = n edges after accept + 1 cycle to visibility, i.e. out_valid first high n+1 cycles after the accept edge's cycle... (exactly: n CALC edges after the accept edge).
  - in_ready=0.
- DONE:
  - out_valid=1; out_data/out_sat held stable while out_ready=0.
  - Edge with out_ready=1 → IDLE, out_valid=0.
  - No input accept in DONE; in_ready rises the cycle after the output handshake.
- Input handling: op/a/b are sampled only at accept; later changes are ignored. out_ready is ignored outside DONE.
- Reset mid-operation: immediate abort; out_valid drops asynchronously; no partial result is ever presented; after deassertion the unit is in IDLE with in_ready=1.
- Extremes: mult MIN*MIN saturates to MAX with out_sat=1. Negative bases are legal for pow.

Test Plan (DATA_W=16, FRAC_W=8, ONE=256):
1. Add 16+16 → out_data=32, out_sat=0, out_valid one cycle after accept. Sub -32768-1 → -32768, out_sat=1.
2. Mult a=-128 (-0.5), b=128 (0.5) → -64, out_sat=0. Mult 32767*32767 → 32767, out_sat=1. Mult -1*1 → -1 (floor).
3. Pow a=512 (2.0), n=3 → 2048, out_valid 3 edges after the accept edge. Pow n=0 → 256 with latency 1. Pow a=512, n=7 → 32767, out_sat=1. Pow a=-512, n=3 → -2048.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data/out_sat stable, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → in_ready=1 next cycle; a back-to-back op completes correctly.
5. Reset mid-pow (a=512, n=15, rst raised at second CALC cycle) → out_valid=0 immediately, out_data=0. After release, in_ready=1 and the next add returns the correct value with no stale output.
6. Randomised ops/operands against a saturating reference model, with random out_ready stalls → every result and out_sat match; exactly one out_valid handshake per accept.
